// File: rtl/mdu_exec_unit.sv
// mdu_exec_unit: iterative RV32M multiply/divide unit between the reservation
// station (issue handshake) and the CDB arbiter (result handshake).
// Multiplies take 2 cycles; divides use a radix-2 restoring loop of
// DATA_WIDTH iterations, with divide-by-zero and signed overflow resolved
// immediately.
// Optional build macro MDU_EARLY_OUT_EN: a divide whose dividend magnitude is
// below the divisor magnitude completes immediately with quotient 0.
module mdu_exec_unit #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ROB_ADDR_WIDTH = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    input  logic                      issue_valid_i,
    output logic                      issue_ready_o,
    input  logic [31:0]               issue_opcode_i,
    input  logic [DATA_WIDTH-1:0]     issue_v_rs1_i,
    input  logic [DATA_WIDTH-1:0]     issue_v_rs2_i,
    input  logic [ROB_ADDR_WIDTH-1:0] issue_rob_tag_i,
    output logic                      result_valid_o,
    input  logic                      result_ready_i,
    output logic [ROB_ADDR_WIDTH-1:0] result_rob_tag_o,
    output logic [DATA_WIDTH-1:0]     result_data_o,
    output logic                      busy_o
);

    localparam int unsigned MSB    = DATA_WIDTH - 1;
    localparam int unsigned CNT_W  = $clog2(DATA_WIDTH);
    localparam int unsigned PROD_W = 2 * DATA_WIDTH + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [2:0]            f3_q;
    logic                  sa_q;
    logic                  sb_q;
    logic                  neg_q_q;
    logic                  neg_r_q;
    logic [DATA_WIDTH-1:0] opa_q;
    logic [DATA_WIDTH-1:0] opb_q;
    logic [DATA_WIDTH-1:0] quo_q;
    logic [DATA_WIDTH-1:0] rem_q;

    // Handshake-facing status, all derived from the registered state
    assign issue_ready_o  = (state_q == S_IDLE);
    assign busy_o         = (state_q != S_IDLE);
    assign result_valid_o = (state_q == S_DONE) && !flush_i;

    // Issue-side decode of the incoming instruction
    logic [2:0]            f3_c;
    logic                  is_div_c;
    logic                  div_signed_c;
    logic                  rs1_neg_c;
    logic                  rs2_neg_c;
    logic [DATA_WIDTH-1:0] mag1_c;
    logic [DATA_WIDTH-1:0] mag2_c;
    logic                  div_zero_c;
    logic                  div_ovf_c;
    logic                  accept_c;

    assign f3_c         = issue_opcode_i[14:12];
    assign is_div_c     = f3_c[2];
    assign div_signed_c = f3_c[2] & ~f3_c[0];
    assign rs1_neg_c    = div_signed_c & issue_v_rs1_i[MSB];
    assign rs2_neg_c    = div_signed_c & issue_v_rs2_i[MSB];
    assign mag1_c       = rs1_neg_c ? -issue_v_rs1_i : issue_v_rs1_i;
    assign mag2_c       = rs2_neg_c ? -issue_v_rs2_i : issue_v_rs2_i;
    assign div_zero_c   = (issue_v_rs2_i == '0);
    assign div_ovf_c    = div_signed_c
                          && (issue_v_rs1_i == {1'b1, {(DATA_WIDTH-1){1'b0}}})
                          && (issue_v_rs2_i == '1);
    assign accept_c     = issue_valid_i && (state_q == S_IDLE) && !flush_i;

    // Divides that resolve without iterating
    logic                  spec_c;
    logic [DATA_WIDTH-1:0] spec_q_c;
    logic [DATA_WIDTH-1:0] spec_r_c;

    always_comb begin
        spec_c   = 1'b0;
        spec_q_c = '0;
        spec_r_c = '0;
        if (div_zero_c) begin
            spec_c   = 1'b1;
            spec_q_c = '1;
            spec_r_c = issue_v_rs1_i;
        end else if (div_ovf_c) begin
            spec_c   = 1'b1;
            spec_q_c = issue_v_rs1_i;
            spec_r_c = '0;
        end
`ifdef MDU_EARLY_OUT_EN
        else if (mag1_c < mag2_c) begin
            spec_c   = 1'b1;
            spec_q_c = '0;
            spec_r_c = issue_v_rs1_i;
        end
`endif
    end

    // Signed 33x33 product covering MUL/MULH/MULHSU/MULHU
    logic signed [DATA_WIDTH:0] a_s_c;
    logic signed [DATA_WIDTH:0] b_s_c;
    logic signed [PROD_W-1:0]   prod_c;

    assign a_s_c  = {sa_q & opa_q[MSB], opa_q};
    assign b_s_c  = {sb_q & opb_q[MSB], opb_q};
    assign prod_c = PROD_W'(a_s_c) * PROD_W'(b_s_c);

    // One restoring-division step on the magnitudes
    logic [DATA_WIDTH:0]   rem_sh_c;
    logic [DATA_WIDTH:0]   diff_c;
    logic                  geq_c;
    logic [DATA_WIDTH-1:0] rem_nx_c;
    logic [DATA_WIDTH-1:0] quo_nx_c;
    logic [DATA_WIDTH-1:0] q_fix_c;
    logic [DATA_WIDTH-1:0] r_fix_c;

    assign rem_sh_c = {rem_q, quo_q[MSB]};
    assign diff_c   = rem_sh_c - {1'b0, opb_q};
    assign geq_c    = ~diff_c[DATA_WIDTH];
    assign rem_nx_c = geq_c ? diff_c[DATA_WIDTH-1:0] : rem_sh_c[DATA_WIDTH-1:0];
    assign quo_nx_c = {quo_q[MSB-1:0], geq_c};
    assign q_fix_c  = neg_q_q ? -quo_nx_c : quo_nx_c;
    assign r_fix_c  = neg_r_q ? -rem_nx_c : rem_nx_c;

    // Instruction-word fields the dispatcher already guarantees, plus product guard bits
    logic unused_c;
    assign unused_c = ^{issue_opcode_i[31:15], issue_opcode_i[11:0],
                        prod_c[PROD_W-1:2*DATA_WIDTH]};

    // State machine, operand capture, iteration and result registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= S_IDLE;
            cnt_q            <= '0;
            f3_q             <= '0;
            sa_q             <= 1'b0;
            sb_q             <= 1'b0;
            neg_q_q          <= 1'b0;
            neg_r_q          <= 1'b0;
            opa_q            <= '0;
            opb_q            <= '0;
            quo_q            <= '0;
            rem_q            <= '0;
            result_rob_tag_o <= '0;
            result_data_o    <= '0;
        end else if (flush_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_c) begin
                        result_rob_tag_o <= issue_rob_tag_i;
                        f3_q             <= f3_c;
                        sa_q             <= (f3_c == 3'b001) || (f3_c == 3'b010);
                        sb_q             <= (f3_c == 3'b001);
                        neg_q_q          <= rs1_neg_c ^ rs2_neg_c;
                        neg_r_q          <= rs1_neg_c;
                        opa_q            <= issue_v_rs1_i;
                        opb_q            <= is_div_c ? mag2_c : issue_v_rs2_i;
                        quo_q            <= mag1_c;
                        rem_q            <= '0;
                        cnt_q            <= '0;
                        if (!is_div_c) begin
                            state_q <= S_MUL;
                        end else if (spec_c) begin
                            result_data_o <= f3_c[1] ? spec_r_c : spec_q_c;
                            state_q       <= S_DONE;
                        end else begin
                            state_q <= S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    result_data_o <= (f3_q == 3'b000) ? prod_c[DATA_WIDTH-1:0]
                                                      : prod_c[2*DATA_WIDTH-1:DATA_WIDTH];
                    state_q       <= S_DONE;
                end
                S_DIV: begin
                    rem_q <= rem_nx_c;
                    quo_q <= quo_nx_c;
                    if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                        result_data_o <= f3_q[1] ? r_fix_c : q_fix_c;
                        cnt_q         <= '0;
                        state_q       <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (result_ready_i) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_exec_unit.sv
// Directed testbench for mdu_exec_unit.
module tb_mdu_exec_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        issue_valid_i;
    logic        issue_ready_o;
    logic [31:0] issue_opcode_i;
    logic [31:0] issue_v_rs1_i;
    logic [31:0] issue_v_rs2_i;
    logic [4:0]  issue_rob_tag_i;
    logic        result_valid_o;
    logic        result_ready_i;
    logic [4:0]  result_rob_tag_o;
    logic [31:0] result_data_o;
    logic        busy_o;

    int total  = 0;
    int passed = 0;

`ifdef MDU_EARLY_OUT_EN
    localparam int EARLY_LAT = 1;
`else
    localparam int EARLY_LAT = 33;
`endif

    mdu_exec_unit #(.DATA_WIDTH(32), .ROB_ADDR_WIDTH(5)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .flush_i          (flush_i),
        .issue_valid_i    (issue_valid_i),
        .issue_ready_o    (issue_ready_o),
        .issue_opcode_i   (issue_opcode_i),
        .issue_v_rs1_i    (issue_v_rs1_i),
        .issue_v_rs2_i    (issue_v_rs2_i),
        .issue_rob_tag_i  (issue_rob_tag_i),
        .result_valid_o   (result_valid_o),
        .result_ready_i   (result_ready_i),
        .result_rob_tag_o (result_rob_tag_o),
        .result_data_o    (result_data_o),
        .busy_o           (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Presents one instruction for a single edge, then waits up to max_wait
    // cycles for result_valid_o; returns at a falling edge.
    task automatic issue_op(input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] tag,
                            input int max_wait, output logic rdy_after,
                            output int lat);
        @(negedge clk_i);
        issue_valid_i   = 1'b1;
        issue_opcode_i  = {7'b0000001, 10'b0, f3, 5'b0, 7'b0110011};
        issue_v_rs1_i   = a;
        issue_v_rs2_i   = b;
        issue_rob_tag_i = tag;
        @(negedge clk_i);
        issue_valid_i = 1'b0;
        rdy_after     = issue_ready_o;
        lat           = 1;
        while (!result_valid_o && lat < max_wait) begin
            @(negedge clk_i);
            lat++;
        end
    endtask

    // Accepts the offered result for one cycle
    task automatic consume();
        result_ready_i = 1'b1;
        @(negedge clk_i);
        result_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        total++; if (issue_ready_o !== 1'b1) $display("FAIL reset_issue_ready got=%b exp=1", issue_ready_o); else passed++;
        total++; if (result_valid_o !== 1'b0) $display("FAIL reset_valid got=%b exp=0", result_valid_o); else passed++;
        total++; if (result_rob_tag_o !== 5'd0) $display("FAIL reset_tag got=%0d exp=0", result_rob_tag_o); else passed++;
        total++; if (result_data_o !== 32'h0) $display("FAIL reset_data got=%h exp=0", result_data_o); else passed++;
        total++; if (busy_o !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy_o); else passed++;
        rst_i = 1'b0;
    endtask

    task automatic test_mul();
        logic [2:0]  f3  [8] = '{3'b000, 3'b011, 3'b010, 3'b001, 3'b001, 3'b010, 3'b011, 3'b000};
        logic [31:0] a   [8] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000,
                                 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678};
        logic [31:0] b   [8] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd2, 32'h80000000,
                                 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'h10};
        logic [31:0] exp [8] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h40000000,
                                 32'h0, 32'hFFFFFFFF, 32'h1, 32'h23456780};
        logic [4:0]  tag;
        logic        rdy;
        int          lat;
        for (int i = 0; i < 8; i++) begin
            tag = (i == 0) ? 5'd5 : 5'(i + 10);
            issue_op(f3[i], a[i], b[i], tag, 60, rdy, lat);
            total++; if (rdy !== 1'b0) $display("FAIL mul%0d_ready_drop got=%b exp=0", i, rdy); else passed++;
            total++; if (lat != 2) $display("FAIL mul%0d_latency got=%0d exp=2", i, lat); else passed++;
            total++; if (result_data_o !== exp[i]) $display("FAIL mul%0d_data got=%h exp=%h", i, result_data_o, exp[i]); else passed++;
            total++; if (result_rob_tag_o !== tag) $display("FAIL mul%0d_tag got=%0d exp=%0d", i, result_rob_tag_o, tag); else passed++;
            consume();
        end
    endtask

    task automatic test_div();
        logic [2:0]  f3  [8] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b101, 3'b111, 3'b100, 3'b110};
        logic [31:0] a   [8] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100,
                                 32'd3, 32'd3, 32'hFFFFFFFD, 32'hFFFFFFFD};
        logic [31:0] b   [8] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd10, 32'd10, 32'd10, 32'd10};
        logic [31:0] exp [8] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2,
                                 32'd0, 32'd3, 32'd0, 32'hFFFFFFFD};
        int          elat[8] = '{33, 33, 33, 33, EARLY_LAT, EARLY_LAT, EARLY_LAT, EARLY_LAT};
        logic        rdy;
        int          lat;
        for (int i = 0; i < 8; i++) begin
            issue_op(f3[i], a[i], b[i], 5'(i + 1), 60, rdy, lat);
            total++; if (lat != elat[i]) $display("FAIL div%0d_latency got=%0d exp=%0d", i, lat, elat[i]); else passed++;
            total++; if (result_data_o !== exp[i]) $display("FAIL div%0d_data got=%h exp=%h", i, result_data_o, exp[i]); else passed++;
            total++; if (result_rob_tag_o !== 5'(i + 1)) $display("FAIL div%0d_tag got=%0d exp=%0d", i, result_rob_tag_o, i + 1); else passed++;
            consume();
        end
    endtask

    task automatic test_special();
        logic [2:0]  f3  [6] = '{3'b101, 3'b111, 3'b100, 3'b110, 3'b100, 3'b110};
        logic [31:0] a   [6] = '{32'd9, 32'd9, 32'h80000000, 32'h80000000, 32'hFFFFFFFB, 32'hFFFFFFFB};
        logic [31:0] b   [6] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
        logic [31:0] exp [6] = '{32'hFFFFFFFF, 32'd9, 32'h80000000, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB};
        logic        rdy;
        int          lat;
        for (int i = 0; i < 6; i++) begin
            issue_op(f3[i], a[i], b[i], 5'(i + 20), 60, rdy, lat);
            total++; if (lat != 1) $display("FAIL spec%0d_latency got=%0d exp=1", i, lat); else passed++;
            total++; if (result_data_o !== exp[i]) $display("FAIL spec%0d_data got=%h exp=%h", i, result_data_o, exp[i]); else passed++;
            total++; if (result_rob_tag_o !== 5'(i + 20)) $display("FAIL spec%0d_tag got=%0d exp=%0d", i, result_rob_tag_o, i + 20); else passed++;
            consume();
        end
    endtask

    task automatic test_backpressure();
        logic rdy;
        int   lat;
        issue_op(3'b000, 32'd6, 32'd7, 5'd9, 60, rdy, lat);
        total++; if (lat != 2) $display("FAIL bp_latency got=%0d exp=2", lat); else passed++;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            total++;
            if (result_valid_o !== 1'b1 || result_data_o !== 32'd42 || result_rob_tag_o !== 5'd9)
                $display("FAIL bp_hold%0d got valid=%b data=%h tag=%0d exp valid=1 data=0000002a tag=9",
                         c, result_valid_o, result_data_o, result_rob_tag_o);
            else passed++;
        end
        consume();
        total++; if (result_valid_o !== 1'b0) $display("FAIL bp_valid_after got=%b exp=0", result_valid_o); else passed++;
        total++; if (issue_ready_o !== 1'b1) $display("FAIL bp_ready_after got=%b exp=1", issue_ready_o); else passed++;
        // Back-to-back issue straight after the CDB handshake
        issue_op(3'b000, 32'd5, 32'd5, 5'd4, 60, rdy, lat);
        total++; if (result_data_o !== 32'd25 || lat != 2) $display("FAIL b2b_mul got data=%h lat=%0d exp data=00000019 lat=2", result_data_o, lat); else passed++;
        consume();
    endtask

    task automatic test_flush();
        logic rdy;
        int   lat;
        logic seen;
        // Flush coincident with issue_valid_i captures nothing
        @(negedge clk_i);
        issue_valid_i  = 1'b1;
        issue_opcode_i = {7'b0000001, 10'b0, 3'b000, 5'b0, 7'b0110011};
        issue_v_rs1_i  = 32'd2;
        issue_v_rs2_i  = 32'd2;
        flush_i        = 1'b1;
        @(negedge clk_i);
        issue_valid_i = 1'b0;
        flush_i       = 1'b0;
        total++; if (busy_o !== 1'b0) $display("FAIL flush_issue_busy got=%b exp=0", busy_o); else passed++;
        // Flush in the middle of a divide
        issue_op(3'b101, 32'd1000, 32'd3, 5'd3, 1, rdy, lat);
        seen = 1'b0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk_i);
            seen |= result_valid_o;
        end
        total++; if (busy_o !== 1'b1) $display("FAIL flush_div_busy got=%b exp=1", busy_o); else passed++;
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        total++; if (busy_o !== 1'b0) $display("FAIL flush_busy_after got=%b exp=0", busy_o); else passed++;
        total++; if (issue_ready_o !== 1'b1) $display("FAIL flush_ready_after got=%b exp=1", issue_ready_o); else passed++;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_i);
            seen |= result_valid_o;
        end
        total++; if (seen !== 1'b0) $display("FAIL flush_no_result got=%b exp=0", seen); else passed++;
        issue_op(3'b000, 32'd3, 32'd4, 5'd7, 60, rdy, lat);
        total++; if (result_data_o !== 32'd12) $display("FAIL flush_mul_data got=%h exp=0000000c", result_data_o); else passed++;
        total++; if (result_rob_tag_o !== 5'd7) $display("FAIL flush_mul_tag got=%0d exp=7", result_rob_tag_o); else passed++;
        // Flush drops a pending result in DONE
        total++; if (result_valid_o !== 1'b1) $display("FAIL flush_done_pre got=%b exp=1", result_valid_o); else passed++;
        flush_i = 1'b1;
        #1;
        total++; if (result_valid_o !== 1'b0) $display("FAIL flush_done_mask got=%b exp=0", result_valid_o); else passed++;
        @(negedge clk_i);
        flush_i = 1'b0;
        total++; if (busy_o !== 1'b0 || result_valid_o !== 1'b0) $display("FAIL flush_done_drop got busy=%b valid=%b exp 0 0", busy_o, result_valid_o); else passed++;
    endtask

    task automatic test_reset_midop();
        logic rdy;
        int   lat;
        issue_op(3'b000, 32'd8, 32'd8, 5'd17, 60, rdy, lat);
        total++; if (result_data_o !== 32'd64) $display("FAIL rst_mid_data got=%h exp=00000040", result_data_o); else passed++;
        rst_i   = 1'b1;
        flush_i = 1'b1;
        @(negedge clk_i);
        rst_i   = 1'b0;
        flush_i = 1'b0;
        total++; if (result_data_o !== 32'h0 || result_rob_tag_o !== 5'd0 || busy_o !== 1'b0)
            $display("FAIL rst_mid_clear got data=%h tag=%0d busy=%b exp 0 0 0", result_data_o, result_rob_tag_o, busy_o);
        else passed++;
    endtask

    initial begin
        rst_i           = 1'b1;
        flush_i         = 1'b0;
        issue_valid_i   = 1'b0;
        issue_opcode_i  = '0;
        issue_v_rs1_i   = '0;
        issue_v_rs2_i   = '0;
        issue_rob_tag_i = '0;
        result_ready_i  = 1'b0;
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_backpressure();
        test_flush();
        test_reset_midop();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mdu_exec_unit.md
Name: mdu_exec_unit

Overview:
Iterative RV32M multiply/divide functional unit. It sits on the issue side of the reservation station: it accepts one ready instruction through the issue valid/ready handshake and computes the result. It then broadcasts that result on the Common Data Bus through a valid/ready handshake into the CDB arbiter. The unit holds one operation at a time and is cleared by the pipeline flush.

Parameters:
DATA_WIDTH, XLEN (32), operand/result width; M-extension semantics are defined for 32.
ROB_ADDR_WIDTH, ROB_ADDR_WIDTH_G, ROB tag width; must match the reservation station and ROB.

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
flush_i  in  1  abort the in-flight operation and drop any pending result
issue_valid_i  in  1  reservation station presents a ready instruction
issue_ready_o  out  1  unit can accept an instruction
issue_opcode_i  in  32  instruction word; only funct3 [14:12] is decoded
issue_v_rs1_i  in  DATA_WIDTH  operand 1 (dividend/multiplicand)
issue_v_rs2_i  in  DATA_WIDTH  operand 2 (divisor/multiplier)
issue_rob_tag_i  in  ROB_ADDR_WIDTH  destination ROB tag
result_valid_o  out  1  result is being offered to the CDB
result_ready_i  in  1  CDB arbiter accepts the result
result_rob_tag_o  out  ROB_ADDR_WIDTH  tag of the result
result_data_o  out  DATA_WIDTH  result value
busy_o  out  1  unit is not in IDLE

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset state: state=IDLE. issue_ready_o=1, result_valid_o=0, result_rob_tag_o=0, result_data_o=0, busy_o=0. Iteration counter=0.
- Priority: reset over flush; flush over everything else.
- States: IDLE, MUL, DIV, DONE.
- issue_ready_o = (state==IDLE). A handshake is issue_valid_i && issue_ready_o && !flush_i. On a handshake, latch tag, funct3, operands and sign flags.
- funct3 mapping: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU. The opcode/funct7 fields are not checked; the dispatcher guarantees them.
- IDLE -> MUL on a multiply handshake.
- MUL: 33-bit sign-extended operands per op, registered 64-bit product, then -> DONE.
  - MUL returns [31:0]; the MULH variants return [63:32].
  - Accept at edge E gives result_valid_o=1 in the cycle after E+1 (2-cycle latency).
- IDLE -> DONE directly for the divide special cases, with result_valid_o in the next cycle:
  - Divisor 0: quotient = all ones; remainder = dividend (for both signed and unsigned).
  - Signed overflow (0x80000000 / -1): quotient = 0x80000000; remainder = 0.
- IDLE -> DIV on any other divide.
  - Signed ops divide absolute values.
  - Radix-2 restoring algorithm: one quotient bit per cycle over 32 cycles. The 5-bit counter counts 0..31; at 31 -> DONE.
  - Result valid 33 cycles after acceptance.
  - Sign fix: the quotient is negated if the operand signs differ; the remainder takes the dividend's sign.
- DONE:
  - result_valid_o = (state==DONE) && !flush_i.
  - Data and tag stay stable while result_ready_i=0, with no cycle limit.
  - The cycle after result_valid_o && result_ready_i, the unit returns to IDLE. The next issue can be accepted one cycle after the CDB handshake.
- Flush: from any state, the next state is IDLE and the counter clears. A flush in the same cycle as issue_valid_i captures nothing. A pending DONE result is dropped and never broadcast.
- busy_o = (state!=IDLE).
- Every result-register update is a full DATA_WIDTH write; no partial writes.

Optional Feature:
MDU_EARLY_OUT_EN
- Defined: in IDLE, any non-special divide with |dividend| < |divisor| (unsigned compare of magnitudes) goes directly to DONE. It returns quotient 0 and remainder = dividend, with result valid in the next cycle.
- Undefined: such divides take the full 32-iteration path and return identical values after 33 cycles.

Test Plan:
1. Reset, then MUL rs1=7, rs2=0xFFFFFFFD, tag 5 -> issue_ready_o drops the next cycle; 2 cycles after acceptance result_valid_o=1, data=0xFFFFFFEB, tag=5.
2. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> data=0xFFFFFFFE. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
3. DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD after 33 cycles. REM with the same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14; REMU 100/7 -> 2. (These divides are taken with the macro undefined.)
4. DIVU 9/0 -> 0xFFFFFFFF; REMU 9/0 -> 9; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0. Each is valid 1 cycle after acceptance.
5. Backpressure: MUL result held with result_ready_i=0 for 5 cycles -> data, tag and valid stay stable. Then ready=1 for one cycle -> valid=0 and issue_ready_o=1 the next cycle.
6. Flush at DIV iteration 10 -> result_valid_o never asserts, busy_o=0 and issue_ready_o=1 the next cycle. A new MUL 3x4 then returns 12.
